axi_slv_rchannel: RTL and testbench

AXI slave read channel for the memory controller; the read-side counterpart of the write channel. Accepts one AR burst at a time, issues one read-request frame per beat to the arbiter, buffers returned read data in a small FIFO, and returns it on the AXI R channel with `rlast`. Credit-based issue guarantees that returned data always has FIFO space.

---
 rtl/mc_axi_pkg.sv | 20 ++
 rtl/axi_slv_rchannel_if.sv | 35 +++
 rtl/axi_rdata_fifo.sv | 49 ++++
 rtl/axi_slv_rchannel.sv | 132 +++++++++++++
 tb/tb_axi_slv_rchannel.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/mc_axi_pkg.sv
// Shared definitions for the memory-controller AXI slave channels.
// Holds default bus widths, the read-request frame layout and FSM state encodings.
// Purely declarative: no logic, no latency, no backpressure.
package mc_axi_pkg;

  localparam int AXI_DATA_WIDTH_DFLT = 256;
  localparam int AXI_ADDR_WIDTH_DFLT = 25;

  // Read-request frame layout at the default width: {last, beat_addr}.
  localparam int RFRAME_LAST_BIT = AXI_ADDR_WIDTH_DFLT;
  localparam int RFRAME_ADDR_MSB = AXI_ADDR_WIDTH_DFLT - 1;
  localparam int RFRAME_ADDR_LSB = 0;

  typedef enum logic [1:0] {
    RCH_IDLE  = 2'd0,
    RCH_REQ   = 2'd1,
    RCH_DRAIN = 2'd2
  } rch_state_t;

endpackage

// File: rtl/axi_slv_rchannel_if.sv
// Bundle of AXI AR/R signals plus the arbiter read-request/return signals.
// No logic, no latency.
// slave modport is the read channel's view; master is the surrounding system's view.
interface axi_slv_rchannel_if #(
  parameter int AXI_DATA_WIDTH = mc_axi_pkg::AXI_DATA_WIDTH_DFLT,
  parameter int AXI_ADDR_WIDTH = mc_axi_pkg::AXI_ADDR_WIDTH_DFLT
) ();
  logic                      axi_s_arvalid;
  logic                      axi_s_arready;
  logic [7:0]                axi_s_arlen;
  logic [AXI_ADDR_WIDTH-1:0] axi_s_araddr;
  logic                      axi_s_rvalid;
  logic                      axi_s_rready;
  logic                      axi_s_rlast;
  logic [AXI_DATA_WIDTH-1:0] axi_s_rdata;
  logic                      axi2arb_rframe_valid;
  logic                      axi2arb_rframe_ready;
  logic [AXI_ADDR_WIDTH:0]   axi2arb_rframe_data;
  logic                      arb2axi_rdata_valid;
  logic [AXI_DATA_WIDTH-1:0] arb2axi_rdata;

  modport slave (
    input  axi_s_arvalid, axi_s_arlen, axi_s_araddr, axi_s_rready,
    input  axi2arb_rframe_ready, arb2axi_rdata_valid, arb2axi_rdata,
    output axi_s_arready, axi_s_rvalid, axi_s_rlast, axi_s_rdata,
    output axi2arb_rframe_valid, axi2arb_rframe_data
  );

  modport master (
    output axi_s_arvalid, axi_s_arlen, axi_s_araddr, axi_s_rready,
    output axi2arb_rframe_ready, arb2axi_rdata_valid, arb2axi_rdata,
    input  axi_s_arready, axi_s_rvalid, axi_s_rlast, axi_s_rdata,
    input  axi2arb_rframe_valid, axi2arb_rframe_data
  );
endinterface

// File: rtl/axi_rdata_fifo.sv
// Show-ahead FIFO buffering returned read data ahead of the AXI R channel.
// Latency: a push is visible at the head one cycle later.
// Backpressure: pushes while full and pops while empty are ignored.
module axi_rdata_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 256
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (PW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      count <= count + (PW+1)'(do_push) - (PW+1)'(do_pop);
    end
  end

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end
endmodule

// File: rtl/axi_slv_rchannel.sv
// AXI slave read channel: one AR burst at a time, one arbiter frame per beat, data back on R.
// Latency: AR -> first frame 1 cycle; return -> rvalid 1 cycle; rlast handshake -> arready 1 cycle.
// Backpressure: frames issue only while in-flight plus buffered beats fit the FIFO, so returns never stall.
module axi_slv_rchannel
  import mc_axi_pkg::*;
#(
  parameter int AXI_DATA_WIDTH = AXI_DATA_WIDTH_DFLT,
  parameter int AXI_ADDR_WIDTH = AXI_ADDR_WIDTH_DFLT,
  parameter int FIFO_DEPTH     = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  axi_slv_rchannel_if.slave  bus
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  rch_state_t                state;
  logic                      arready_q;
  logic [AXI_ADDR_WIDTH-1:0] base;
  logic [7:0]                len;
  logic [8:0]                req_cnt;
  logic [8:0]                rsp_cnt;
  logic [CW-1:0]             outstanding;

  logic                      fifo_push;
  logic                      fifo_full;
  logic                      fifo_empty;
  logic [CW-1:0]             fifo_count;
  logic [AXI_DATA_WIDTH-1:0] fifo_head;

  logic [CW:0]               inflight;
  logic                      credit_ok;
  logic                      frame_vld;
  logic                      frame_hs;
  logic                      req_last;
  logic                      ret_ok;
  logic                      ar_hs;
  logic                      r_hs;
  logic                      rlast;

  assign inflight  = {1'b0, outstanding} + {1'b0, fifo_count};
  assign credit_ok = inflight < (CW+1)'(FIFO_DEPTH);
  assign frame_vld = (state == RCH_REQ) && credit_ok;
  assign frame_hs  = frame_vld && bus.axi2arb_rframe_ready;
  assign req_last  = (req_cnt == {1'b0, len});
  // Returns with nothing outstanding are strays (e.g. from before a reset) and are discarded.
  assign ret_ok    = bus.arb2axi_rdata_valid && (outstanding != '0);
  assign fifo_push = ret_ok && !fifo_full;
  assign ar_hs     = arready_q && bus.axi_s_arvalid;
  assign r_hs      = !fifo_empty && bus.axi_s_rready;
  assign rlast     = !fifo_empty && (rsp_cnt == {1'b0, len});

  assign bus.axi_s_arready        = arready_q;
  assign bus.axi2arb_rframe_valid = frame_vld;
  assign bus.axi2arb_rframe_data  = (state == RCH_REQ)
                                    ? {req_last, base + AXI_ADDR_WIDTH'(req_cnt)} : '0;
  assign bus.axi_s_rvalid         = !fifo_empty;
  assign bus.axi_s_rlast          = rlast;
  assign bus.axi_s_rdata          = fifo_empty ? '0 : fifo_head;

  // Burst FSM: accept AR, issue frames, drain R until the last beat is taken.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= RCH_IDLE;
      arready_q <= 1'b0;
      base      <= '0;
      len       <= '0;
      req_cnt   <= '0;
      rsp_cnt   <= '0;
    end else begin
      if (r_hs) rsp_cnt <= rsp_cnt + 9'd1;
      case (state)
        RCH_IDLE: begin
          arready_q <= 1'b1;
          if (ar_hs) begin
            arready_q <= 1'b0;
            base      <= bus.axi_s_araddr;
            len       <= bus.axi_s_arlen;
            req_cnt   <= '0;
            rsp_cnt   <= '0;
            state     <= RCH_REQ;
          end
        end
        RCH_REQ: begin
          if (frame_hs) begin
            req_cnt <= req_cnt + 9'd1;
            if (req_last) state <= RCH_DRAIN;
          end
        end
        RCH_DRAIN: begin
          if (r_hs && rlast) begin
            state     <= RCH_IDLE;
            arready_q <= 1'b1;
          end
        end
        default: state <= RCH_IDLE;
      endcase
    end
  end

  // Frames requested but not yet returned; issue and return in one cycle cancel.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      outstanding <= '0;
    end else begin
      case ({frame_hs, ret_ok})
        2'b10:   outstanding <= outstanding + CW'(1);
        2'b01:   outstanding <= outstanding - CW'(1);
        default: outstanding <= outstanding;
      endcase
    end
  end

  axi_rdata_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (AXI_DATA_WIDTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (fifo_push),
    .wdata (bus.arb2axi_rdata),
    .pop   (r_hs),
    .rdata (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // A return into a full buffer means the arbiter broke the credit contract.
  a_no_return_when_full: assert property (@(posedge clk) disable iff (!rst_n)
    !(bus.arb2axi_rdata_valid && fifo_full));
endmodule

// File: tb/tb_axi_slv_rchannel.sv
module tb_axi_slv_rchannel;
  import mc_axi_pkg::*;

  localparam int DW    = 256;
  localparam int AW    = 25;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  axi_slv_rchannel_if #(.AXI_DATA_WIDTH(DW), .AXI_ADDR_WIDTH(AW)) bus ();

  axi_slv_rchannel #(
    .AXI_DATA_WIDTH (DW),
    .AXI_ADDR_WIDTH (AW),
    .FIFO_DEPTH     (DEPTH)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Stimulus knobs
  int fr_pct = 100, rr_pct = 100, ret_lo = 1, ret_hi = 1;
  bit stray = 1'b0;

  // Reference model: pending AR requests, current burst progress, arbiter and R expectations.
  logic [AW-1:0]  ar_addr_q[$];
  int             ar_len_q[$];
  bit             busy, alive;
  logic [AW-1:0]  base_m;
  int             len_m, issued, delivered, bursts_done;
  int             ret_due[$];
  logic [DW-1:0]  ret_dat[$];
  logic [DW-1:0]  exp_r[$];
  int             cyc = 0;
  bit             stall_prev = 1'b0;
  logic [AW:0]    prev_fdata;

  task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [DW-1:0] rnd256();
    logic [DW-1:0] r;
    for (int i = 0; i < DW/32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  // One clock: drive inputs at the falling edge, update the model at the rising edge,
  // then compare DUT outputs against the model at the next falling edge.
  task automatic tick();
    logic ar_hs, f_hs, r_hs, ret_v, stall_next;
    logic [DW-1:0] ret_d;
    if (stall_prev) begin
      chk("frame_hold_vld", bus.axi2arb_rframe_valid, 1);
      chk("frame_hold_dat", bus.axi2arb_rframe_data, prev_fdata);
    end
    bus.axi_s_arvalid = (ar_addr_q.size() > 0);
    bus.axi_s_araddr  = (ar_addr_q.size() > 0) ? ar_addr_q[0] : AW'($urandom);
    bus.axi_s_arlen   = (ar_len_q.size() > 0) ? 8'(ar_len_q[0]) : 8'($urandom);
    bus.axi2arb_rframe_ready = ($urandom_range(99) < fr_pct);
    bus.axi_s_rready         = ($urandom_range(99) < rr_pct);
    ret_v = stray || (ret_due.size() > 0 && ret_due[0] <= cyc + 1);
    ret_d = (!stray && ret_dat.size() > 0) ? ret_dat[0] : rnd256();
    bus.arb2axi_rdata_valid = ret_v;
    bus.arb2axi_rdata       = ret_d;

    ar_hs = bus.axi_s_arvalid && bus.axi_s_arready;
    f_hs  = bus.axi2arb_rframe_valid && bus.axi2arb_rframe_ready;
    r_hs  = bus.axi_s_rvalid && bus.axi_s_rready;
    if (f_hs)
      chk("frame_dat", bus.axi2arb_rframe_data, {issued == len_m, base_m + AW'(issued)});
    if (r_hs) begin
      if (exp_r.size() > 0) chk("rdata", bus.axi_s_rdata, exp_r[0]);
      else                  chk("r_unexpected", 1, 0);
    end
    stall_next = bus.axi2arb_rframe_valid && !bus.axi2arb_rframe_ready;
    prev_fdata = bus.axi2arb_rframe_data;

    @(posedge clk);
    cyc++;
    if (!rst_n) begin
      busy = 0; alive = 0; issued = 0; delivered = 0; len_m = 0;
      ar_addr_q.delete(); ar_len_q.delete();
      ret_due.delete(); ret_dat.delete(); exp_r.delete();
      stall_prev = 0;
    end else begin
      alive = 1;
      stall_prev = stall_next;
      if (ar_hs) begin
        base_m = ar_addr_q.pop_front();
        len_m  = ar_len_q.pop_front();
        busy = 1; issued = 0; delivered = 0;
      end
      if (f_hs) begin
        issued++;
        ret_due.push_back(cyc + $urandom_range(ret_hi, ret_lo));
        ret_dat.push_back(rnd256());
      end
      if (ret_v && !stray && ret_dat.size() > 0) begin
        void'(ret_due.pop_front());
        exp_r.push_back(ret_dat.pop_front());
      end
      if (r_hs && exp_r.size() > 0) begin
        void'(exp_r.pop_front());
        delivered++;
        if (delivered == len_m + 1) begin
          chk("burst_frames", issued, len_m + 1);
          busy = 0;
          bursts_done++;
        end
      end
    end

    @(negedge clk);
    chk("arready", bus.axi_s_arready, !busy && alive);
    chk("rvalid", bus.axi_s_rvalid, exp_r.size() > 0);
    chk("rlast", bus.axi_s_rlast, exp_r.size() > 0 && delivered == len_m);
    chk("rframe_vld", bus.axi2arb_rframe_valid,
        busy && issued <= len_m && (issued - delivered) < DEPTH);
  endtask

  task automatic push_ar(input logic [AW-1:0] a, input int l);
    ar_addr_q.push_back(a);
    ar_len_q.push_back(l);
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n = 0;
    while ((busy || ar_addr_q.size() > 0) && n < budget) begin
      tick();
      n++;
    end
    if (busy || ar_addr_q.size() > 0) chk({tag, "_timeout"}, 1, 0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_arready"}, bus.axi_s_arready, 0);
    chk({tag, "_rvalid"},  bus.axi_s_rvalid, 0);
    chk({tag, "_rlast"},   bus.axi_s_rlast, 0);
    chk({tag, "_rdata"},   bus.axi_s_rdata, 0);
    chk({tag, "_fvalid"},  bus.axi2arb_rframe_valid, 0);
    chk({tag, "_fdata"},   bus.axi2arb_rframe_data, 0);
  endtask

  initial begin
    int n, done0;
    bus.axi_s_arvalid = 0; bus.axi_s_araddr = '0; bus.axi_s_arlen = '0;
    bus.axi_s_rready = 0; bus.axi2arb_rframe_ready = 0;
    bus.arb2axi_rdata_valid = 0; bus.arb2axi_rdata = '0;
    busy = 0; alive = 0; issued = 0; delivered = 0; len_m = 0; bursts_done = 0;
    base_m = '0; prev_fdata = '0;

    @(negedge clk);
    rst_n = 0;
    tick(); tick();
    chk_all_zero("reset");
    rst_n = 1;
    tick();

    // Single beat, return three cycles after the frame
    fr_pct = 100; rr_pct = 100; ret_lo = 3; ret_hi = 3;
    done0 = bursts_done;
    push_ar(AW'(24), 0);
    wait_idle("single", 100);
    tick();
    chk("single_bursts", bursts_done - done0, 1);

    // Long burst, one return per cycle
    ret_lo = 1; ret_hi = 1;
    push_ar(AW'(24), 32);
    wait_idle("long", 400);

    // Credit stall: R blocked, immediate returns
    rr_pct = 0;
    push_ar(AW'(1000), 15);
    for (int i = 0; i < 20; i++) tick();
    chk("stall_issued", issued, DEPTH);
    chk("stall_fvalid", bus.axi2arb_rframe_valid, 0);
    rr_pct = 100;
    wait_idle("stall", 400);
    chk("stall_delivered", delivered, 16);

    // Frame backpressure across the address wrap
    fr_pct = 50; ret_lo = 1; ret_hi = 4;
    push_ar(25'h1FFFFFE, 3);
    wait_idle("wrap", 400);

    // Second AR waiting while the first burst is in flight
    fr_pct = 70; rr_pct = 70;
    done0 = bursts_done;
    push_ar(AW'(100), 5);
    push_ar(AW'(200), 2);
    wait_idle("busy_ar", 600);
    chk("busy_ar_bursts", bursts_done - done0, 2);

    // Reset after five of seventeen beats, then stray returns, then a fresh burst
    fr_pct = 100; rr_pct = 100; ret_lo = 1; ret_hi = 1;
    push_ar(AW'(500), 16);
    n = 0;
    while (delivered < 5 && n < 200) begin tick(); n++; end
    chk("midrst_progress", delivered, 5);
    rst_n = 0;
    tick();
    chk_all_zero("midrst");
    rst_n = 1;
    stray = 1;
    for (int i = 0; i < 4; i++) tick();
    stray = 0;
    tick();
    push_ar(AW'(700), 4);
    wait_idle("post_rst", 200);

    // Random bursts
    for (int b = 0; b < 8; b++) begin
      fr_pct = $urandom_range(100, 30);
      rr_pct = $urandom_range(100, 30);
      ret_lo = 1; ret_hi = $urandom_range(6, 1);
      push_ar(AW'($urandom), $urandom_range(40, 0));
      wait_idle("rand", 2000);
    end
    for (int i = 0; i < 3; i++) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
